alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Shares one combinational ALU (alu_riscv) between NUM_REQ requesters, e.g. the execute stage, the branch unit and a debug/CSR path.
- Each requester has a valid/ready request channel.
- Arbitration is round-robin. The ALU output is captured in a one-entry response register.
- The single response channel carries the source requester index, so each consumer can demultiplex its own result.

Parameters:
- NUM_REQ, 2, number of requesters (legal range 2..8).
- ID_W, $clog2(NUM_REQ), width of requester index; derived, not overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester request accepted this cycle.
- req_a_i  in  NUM_REQ*32  operand A per requester; requester k uses bits [32k+31:32k].
- req_b_i  in  NUM_REQ*32  operand B per requester.
- req_op_i  in  NUM_REQ*5  ALU opcode per requester, from alu_opcodes_pkg.
- rsp_valid_o  out  1  response register holds a result.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_id_o  out  ID_W  index of the requester that issued the response.
- rsp_result_o  out  32  captured result_o.
- rsp_flag_o  out  1  captured flag_o.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, rsp_flag_o=0.
  - Priority pointer = 0. req_ready_o = 0 while reset is held.
- Reset mid-operation: a pending response is dropped; nothing is replayed.
- Capacity: out_free = !rsp_valid_o || rsp_ready_i, i.e. the slot is free or is being drained this cycle.
- Grant:
  - Combinational round-robin. Search begins at the pointer, wraps at NUM_REQ-1 to 0, and picks the first asserted req_valid_i.
  - At most one requester is granted per cycle.
- Ready:
  - req_ready_o[k] = out_free && grant[k].
  - Depends on req_valid_i; requesters must not make valid depend on ready.
- Datapath: the granted operands and opcode are muxed into the ALU instance. If nothing is granted, the ALU inputs are driven from index 0 and the result is unused.
- Handshake at the clock edge:
  - Acceptance (req_valid_i[k] && req_ready_o[k]):
    - Loads rsp_result_o, rsp_flag_o and rsp_id_o=k; sets rsp_valid_o=1.
    - Advances the pointer to k+1 mod NUM_REQ.
  - Drain without acceptance: rsp_valid_o && rsp_ready_i and no new grant clears rsp_valid_o. Data registers hold their last value.
  - Simultaneous drain and accept: the new result replaces the old one and rsp_valid_o stays 1. This gives full throughput of one op per cycle.
  - Stall: rsp_valid_o && !rsp_ready_i forces all req_ready_o=0. Response outputs stay stable until taken.
- Latency: a result accepted at edge N is visible on rsp_* after edge N, and is consumable at edge N+1.
- Pointer: unchanged when nothing is accepted.
- Fairness: with all requesters continuously valid and no stall, grants rotate 0,1,...,NUM_REQ-1,0.
- Opcodes: unsupported opcodes produce result 0 and flag 0, the ALU default. No error is raised.
- Request hold rule: once valid, a requester holds a, b and op stable until ready. The block does not check this.

Optional Feature:
- Macro: ALU_SHARE_ARB_STATS_EN.
- With the macro:
  - Adds output stat_grant_cnt_o, NUM_REQ*16: one saturating 16-bit counter per requester, incremented on each accepted request.
  - Adds output stat_stall_cnt_o, 16: saturating count of cycles with rsp_valid_o && !rsp_ready_i.
  - Adds input stat_clr_i, 1: synchronous clear of all counters. It overrides any same-cycle increment.
  - All counters reset to 0 by rst_ni.
- Without the macro: these ports and registers do not exist and function is otherwise identical.

Decomposition:
- Package alu_share_pkg holds:
  - a localparam of the maximum supported requester count (8);
  - the alu_rsp_t struct {id, result, flag};
  - the stat counter width (16).
- Opcodes continue to come from alu_opcodes_pkg.
- Sub-module rr_arb: parameterised round-robin arbiter with pointer register, inputs req/advance, outputs one-hot grant and index. Reusable for later shared units.
- The ALU itself is instantiated unchanged.

Test Plan:
- Single op: after reset, req0 ADD a=5 b=7 → req_ready_o[0]=1 that cycle; next cycle rsp_valid=1, id=0, result=12, flag=0.
- Round-robin: requesters 0 and 1 both valid every cycle, rsp_ready=1 → accepted ids alternate 0,1,0,1; one response per cycle with no bubbles.
- Backpressure: rsp_ready=0 for 3 cycles with pending SUB 10-3 → rsp_result holds 7 and all req_ready_o=0 for 3 cycles. Then rsp_ready=1 with req1 valid gives drain and accept in the same cycle, and rsp_valid stays 1.
- Flag path: req1 LTS a=0xFFFFFFFF b=1 → flag=1, result=0. Then LTU with same operands → flag=0.
- Async reset mid-stall: rsp_valid=1 then rst_ni low between edges → rsp_valid_o goes 0 immediately. After release, the pointer is 0 and req0 wins over req1 when both are valid.
- Stats (macro defined): 5 accepts by req0, 2 by req1, 4 stall cycles → counters read 5, 2, 4. stat_clr_i pulse → all 0. Force 65535 grants → counter saturates at 0xFFFF.

Source files
------------

// File: rtl/alu_opcodes_pkg.sv
// ALU opcode encodings shared by the execute stage and shared-ALU users.
// Comparison ops drive flag only; the rest drive result only.
package alu_opcodes_pkg;

  localparam int ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_XOR  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_AND  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLTS = 5'd8,
    ALU_SLTU = 5'd9,
    ALU_EQ   = 5'd16,
    ALU_NE   = 5'd17,
    ALU_LTS  = 5'd18,
    ALU_LTU  = 5'd19,
    ALU_GES  = 5'd20,
    ALU_GEU  = 5'd21
  } alu_op_e;

endpackage

// File: rtl/alu_share_pkg.sv
// Shared types for the round-robin shared-ALU wrapper.
// Counter width applies when ALU_SHARE_ARB_STATS_EN is defined.
package alu_share_pkg;

  localparam int MAX_REQ  = 8;
  localparam int MAX_ID_W = 3;
  localparam int STAT_W   = 16;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [31:0]         result;
    logic                flag;
  } alu_rsp_t;

endpackage

// File: rtl/alu_riscv.sv
// Combinational RV32 ALU: arithmetic/logic/shift on result_o,
// branch comparisons on flag_o; unknown opcodes give zeros.
module alu_riscv
  import alu_opcodes_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  op_i,
  output logic [31:0] result_o,
  output logic        flag_o
);

  logic lts;
  logic ltu;
  logic eq;

  assign lts = $signed(a_i) < $signed(b_i);
  assign ltu = a_i < b_i;
  assign eq  = a_i == b_i;

  // opcode decode
  always_comb begin
    result_o = '0;
    flag_o   = 1'b0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_SLL:  result_o = a_i << b_i[4:0];
      ALU_SRL:  result_o = a_i >> b_i[4:0];
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      ALU_SLTS: result_o = {31'b0, lts};
      ALU_SLTU: result_o = {31'b0, ltu};
      ALU_EQ:   flag_o   = eq;
      ALU_NE:   flag_o   = !eq;
      ALU_LTS:  flag_o   = lts;
      ALU_LTU:  flag_o   = ltu;
      ALU_GES:  flag_o   = !lts;
      ALU_GEU:  flag_o   = !ltu;
      default:  ;
    endcase
  end

endmodule

// File: rtl/alu_share_arb_rr_arb.sv
// Round-robin arbiter: search starts at the pointer and wraps;
// the pointer moves past the winner only when advance_i is set.
module rr_arb #(
  parameter int N    = 2,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic            advance_i,
  output logic [N-1:0]    grant_o,
  output logic [ID_W-1:0] idx_o
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] cand;
  logic            found;

  // first requester at or after the pointer
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % N);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        grant_o[cand]  = 1'b1;
        idx_o          = cand;
      end
    end
  end

  // pointer moves to winner+1 on accepted grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (idx_o == ID_W'(N - 1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// One ALU shared by NUM_REQ requesters, round-robin, 1-entry rsp reg.
// Define ALU_SHARE_ARB_STATS_EN for grant/stall counters.
module alu_share_arb
  import alu_share_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*32-1:0]     req_a_i,
  input  logic [NUM_REQ*32-1:0]     req_b_i,
  input  logic [NUM_REQ*5-1:0]      req_op_i,
`ifdef ALU_SHARE_ARB_STATS_EN
  input  logic                      stat_clr_i,
  output logic [NUM_REQ*STAT_W-1:0] stat_grant_cnt_o,
  output logic [STAT_W-1:0]         stat_stall_cnt_o,
`endif
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic [31:0]               rsp_result_o,
  output logic                      rsp_flag_o
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               out_free;
  logic               accept;
  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [4:0]         alu_op;
  logic [31:0]        alu_res;
  logic               alu_flag;
  logic               rsp_valid_q;
  alu_rsp_t           rsp_q;
  logic               unused_id;

  assign out_free    = !rsp_valid_q || rsp_ready_i;
  assign accept      = rst_ni && out_free && (|grant);
  assign req_ready_o = grant & {NUM_REQ{rst_ni && out_free}};

  rr_arb #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_valid_i),
    .advance_i (accept),
    .grant_o   (grant),
    .idx_o     (gnt_idx)
  );

  // gnt_idx is 0 when idle, so the mux defaults to requester 0
  assign alu_a  = req_a_i[int'(gnt_idx)*32 +: 32];
  assign alu_b  = req_b_i[int'(gnt_idx)*32 +: 32];
  assign alu_op = req_op_i[int'(gnt_idx)*5 +: 5];

  alu_riscv u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_res),
    .flag_o   (alu_flag)
  );

  // response slot: load on accept, clear on drain-only
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_q       <= '{id: MAX_ID_W'(gnt_idx),
                       result: alu_res,
                       flag: alu_flag};
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_q.id[ID_W-1:0];
  assign rsp_result_o = rsp_q.result;
  assign rsp_flag_o   = rsp_q.flag;
  assign unused_id    = ^rsp_q.id;

`ifdef ALU_SHARE_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] grant_cnt_q;
  logic [STAT_W-1:0]              stall_cnt_q;

  // saturating counters; clear beats increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (stat_clr_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (accept && grant[k] && (grant_cnt_q[k] != '1)) begin
          grant_cnt_q[k] <= grant_cnt_q[k] + 1'b1;
        end
      end
      if (rsp_valid_q && !rsp_ready_i && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stat_grant_cnt_o = grant_cnt_q;
  assign stat_stall_cnt_o = stall_cnt_q;
`endif

endmodule
